// File: rtl/ram_burst_master.sv
// rtl/ram_burst_master.sv - read/write burst initiator for the simulation RAM helper port
// Optional wrap bursts: define RAM_BURST_MASTER_WRAP_EN.
module ram_burst_master #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  // command channel
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [63:0]      req_idx,
  input  logic [LEN_W-1:0] req_len,
  input  logic             req_wrap,
  // write-beat channel
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [63:0]      wr_data,
  input  logic [63:0]      wr_mask,
  // read-beat channel
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [63:0]      rd_data,
  output logic             rd_last,
  // status
  output logic             done_valid,
  output logic             busy,
  // RAM helper port
  output logic             ram_en,
  output logic [63:0]      ram_rIdx,
  input  logic [63:0]      ram_rdata,
  output logic [63:0]      ram_wIdx,
  output logic [63:0]      ram_wdata,
  output logic [63:0]      ram_wmask,
  output logic             ram_wen
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  // burst progress
  logic [63:0]      beat_idx;
  logic [LEN_W-1:0] beats_left;
  logic [63:0]      idx_next;
  logic             last_beat;

  // handshake / issue strobes
  logic             req_fire;
  logic             wr_fire;
  logic             rd_issue;
  logic             rd_pop;

  // read beat currently on the RAM port, pushed into the buffer at cycle end
  logic             rd_inflight;
  logic             inflight_last;

  // two-entry read return buffer
  logic [63:0]      buf_data [2];
  logic             buf_last [2];
  logic             buf_rd_ptr;
  logic             buf_wr_ptr;
  logic [1:0]       buf_count;
  logic [2:0]       occupancy;

  assign last_beat = (beats_left == '0);
  assign rd_valid  = (buf_count != 2'd0);
  assign rd_data   = buf_data[buf_rd_ptr];
  assign rd_last   = buf_last[buf_rd_ptr];
  assign rd_pop    = rd_valid && rd_ready;
  assign busy      = (state != IDLE) || rd_inflight || (buf_count != 2'd0);

  // Beats already owed to the buffer: stored entries plus the one on the RAM port.
  assign occupancy = {1'b0, buf_count} + {2'b00, rd_inflight};

`ifdef RAM_BURST_MASTER_WRAP_EN
  logic             wrap_q;
  logic [LEN_W-1:0] len_q;
  logic [63:0]      len_mask;
  logic             len_pow2;

  // A wrap burst needs a power-of-two beat count; len is then an all-ones low mask.
  assign len_pow2 = ((req_len & (req_len + LEN_W'(1))) == '0);
  assign len_mask = 64'(len_q);
  assign idx_next = wrap_q ? ((beat_idx & ~len_mask) | ((beat_idx + 64'd1) & len_mask))
                           : (beat_idx + 64'd1);

  // Capture wrap qualification for the accepted command.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
      len_q  <= '0;
    end else if (req_fire) begin
      wrap_q <= req_wrap && len_pow2;
      len_q  <= req_len;
    end
  end
`else
  logic unused_wrap;

  assign unused_wrap = req_wrap;
  assign idx_next    = beat_idx + 64'd1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    wr_ready   = 1'b0;
    req_fire   = 1'b0;
    wr_fire    = 1'b0;
    rd_issue   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        req_fire  = req_valid && !reset;
        if (req_fire) begin
          state_next = req_write ? WRITE : READ;
        end
      end
      READ: begin
        // Only issue when the beat is guaranteed a buffer slot on return.
        rd_issue = !reset && (occupancy < (3'd2 + {2'b00, rd_pop}));
        if (rd_issue && last_beat) begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        wr_ready = !reset;
        wr_fire  = wr_valid && !reset;
        if (wr_fire && last_beat) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Burst index and remaining-beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_idx   <= 64'd0;
      beats_left <= '0;
    end else if (req_fire) begin
      beat_idx   <= req_idx;
      beats_left <= req_len;
    end else if (rd_issue || wr_fire) begin
      beat_idx <= idx_next;
      if (!last_beat) begin
        beats_left <= beats_left - LEN_W'(1);
      end
    end
  end

  // Registered RAM port; index/data hold between beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_en        <= 1'b0;
      ram_wen       <= 1'b0;
      ram_rIdx      <= 64'd0;
      ram_wIdx      <= 64'd0;
      ram_wdata     <= 64'd0;
      ram_wmask     <= 64'd0;
      done_valid    <= 1'b0;
      rd_inflight   <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      ram_en        <= rd_issue || wr_fire;
      ram_wen       <= wr_fire;
      done_valid    <= wr_fire && last_beat;
      rd_inflight   <= rd_issue;
      inflight_last <= rd_issue && last_beat;
      if (rd_issue) begin
        ram_rIdx <= beat_idx;
      end
      if (wr_fire) begin
        ram_wIdx  <= beat_idx;
        ram_wdata <= wr_data;
        ram_wmask <= wr_mask;
      end
    end
  end

  // Read return buffer: push the in-flight beat, pop on rd handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_data[0] <= 64'd0;
      buf_data[1] <= 64'd0;
      buf_last[0] <= 1'b0;
      buf_last[1] <= 1'b0;
      buf_rd_ptr  <= 1'b0;
      buf_wr_ptr  <= 1'b0;
      buf_count   <= 2'd0;
    end else begin
      if (rd_inflight) begin
        buf_data[buf_wr_ptr] <= ram_rdata;
        buf_last[buf_wr_ptr] <= inflight_last;
        buf_wr_ptr           <= ~buf_wr_ptr;
      end
      if (rd_pop) begin
        buf_rd_ptr <= ~buf_rd_ptr;
      end
      case ({rd_inflight, rd_pop})
        2'b10:   buf_count <= buf_count + 2'd1;
        2'b01:   buf_count <= buf_count - 2'd1;
        default: buf_count <= buf_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// tb/tb_ram_burst_master.sv - self-checking bench for ram_burst_master
module tb_ram_burst_master;

  localparam int LEN_W = 8;
`ifdef RAM_BURST_MASTER_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_write = 1'b0;
  logic [63:0]      req_idx = 64'd0;
  logic [LEN_W-1:0] req_len = '0;
  logic             req_wrap = 1'b0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [63:0]      wr_data = 64'd0;
  logic [63:0]      wr_mask = 64'd0;
  logic             rd_valid;
  logic             rd_ready = 1'b1;
  logic [63:0]      rd_data;
  logic             rd_last;
  logic             done_valid;
  logic             busy;
  logic             ram_en;
  logic [63:0]      ram_rIdx;
  logic [63:0]      ram_rdata;
  logic [63:0]      ram_wIdx;
  logic [63:0]      ram_wdata;
  logic [63:0]      ram_wmask;
  logic             ram_wen;

  ram_burst_master #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_idx(req_idx), .req_len(req_len), .req_wrap(req_wrap),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done_valid(done_valid), .busy(busy),
    .ram_en(ram_en), .ram_rIdx(ram_rIdx), .ram_rdata(ram_rdata),
    .ram_wIdx(ram_wIdx), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_wen(ram_wen)
  );

  always #5 clk = ~clk;

  // RAM helper model: 1024 words, combinational read, masked write.
  logic [63:0] mem [1024];
  logic [63:0] ref_mem [1024];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = 10'd0;
  logic [63:0] pl_data = 64'd0;

  assign ram_rdata = mem[ram_rIdx[9:0]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (ram_en && ram_wen)
      mem[ram_wIdx[9:0]] <= (mem[ram_wIdx[9:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard queues.
  typedef struct packed { logic [63:0] data; logic last; } rd_exp_t;
  typedef struct packed { logic [63:0] idx; logic [63:0] data; logic [63:0] mask; logic done; } wr_exp_t;
  rd_exp_t     rd_q[$];
  logic [63:0] ridx_q[$];
  wr_exp_t     wr_q[$];
  int          outstanding = 0;
  int          done_cnt = 0;
  logic [63:0] last_ridx = 64'd0;
  logic [63:0] last_rdata = 64'd0;

  // Monitor samples DUT outputs on the falling edge.
  always @(negedge clk) begin
    rd_exp_t re;
    wr_exp_t we;
    logic [63:0] ie;
    if (ram_en && !ram_wen) begin
      outstanding++;
      check("rd_room", 64'(outstanding <= 2), 64'd1);
      if (ridx_q.size() == 0) check("rd_extra_issue", 64'(ridx_q.size()), 64'd1);
      else begin
        ie = ridx_q.pop_front();
        check("ram_rIdx", ram_rIdx, ie);
      end
      last_ridx = ram_rIdx;
    end
    if (rd_valid && rd_ready) begin
      outstanding--;
      if (rd_q.size() == 0) check("rd_extra_beat", 64'(rd_q.size()), 64'd1);
      else begin
        re = rd_q.pop_front();
        check("rd_data", rd_data, re.data);
        check("rd_last", 64'(rd_last), 64'(re.last));
      end
      if (rd_last) last_rdata = rd_data;
    end
    if (ram_wen) begin
      check("wen_has_en", 64'(ram_en), 64'd1);
      if (wr_q.size() == 0) check("wr_extra_beat", 64'(wr_q.size()), 64'd1);
      else begin
        we = wr_q.pop_front();
        check("ram_wIdx", ram_wIdx, we.idx);
        check("ram_wdata", ram_wdata, we.data);
        check("ram_wmask", ram_wmask, we.mask);
        check("done_valid", 64'(done_valid), 64'(we.done));
      end
    end else if (done_valid) begin
      check("done_stray", 64'(done_valid), 64'd0);
    end
    if (done_valid) done_cnt++;
  end

  // Read-ready pattern: 0 = held high, 1 = toggle, 2 = random.
  int stall_mode = 0;
  always @(posedge clk) begin
    #1;
    case (stall_mode)
      0:       rd_ready = 1'b1;
      1:       rd_ready = ~rd_ready;
      default: rd_ready = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic logic [63:0] nxt(input logic [63:0] i, input logic [7:0] len, input logic wrap);
    logic [8:0] l9;
    l9 = {1'b0, len};
    if (WRAP_EN && wrap && (((l9 + 9'd1) & l9) == 9'd0))
      return (i & ~{56'd0, len}) | ((i + 64'd1) & {56'd0, len});
    return i + 64'd1;
  endfunction

  task automatic preload(input logic [9:0] idx, input logic [63:0] data);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    ref_mem[idx] = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic send_req(input logic w, input logic [63:0] idx, input logic [7:0] len,
                          input logic wrap, input bit lat);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_idx = idx; req_len = len; req_wrap = wrap;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) check("req_ready_timeout", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (lat) begin
      @(negedge clk); check("lat_c1_ram_en", 64'(ram_en), 64'd0);
      @(negedge clk); check("lat_c2_ram_en", 64'(ram_en), 64'd1);
      @(negedge clk); check("lat_c3_rd_valid", 64'(rd_valid), 64'd1);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || rd_q.size() != 0 || wr_q.size() != 0) && n < 500) begin
      @(negedge clk); n++;
    end
    check({name, "_idle"}, 64'(busy), 64'd0);
    check({name, "_drained"}, 64'(rd_q.size() + wr_q.size() + ridx_q.size()), 64'd0);
  endtask

  typedef struct {
    logic [63:0] idx;
    logic [7:0]  len;
    logic        wrap;
    int          stall;
    logic [63:0] exp_last_idx;
    logic [63:0] exp_last_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] i;
    wr_exp_t     we;
    logic [63:0] mask;

    vecs[0] = '{64'h100, 8'd3, 1'b0, 0, 64'h103, 64'hA3};
    vecs[1] = '{64'h100, 8'd3, 1'b0, 1, 64'h103, 64'hA3};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'd1, 1'b0, 0, 64'h0, 64'hF1};
    if (WRAP_EN) vecs[3] = '{64'h106, 8'd3, 1'b1, 0, 64'h105, 64'hA5};
    else         vecs[3] = '{64'h106, 8'd3, 1'b1, 0, 64'h109, 64'hA9};
    vecs[4] = '{64'h106, 8'd2, 1'b1, 0, 64'h108, 64'hA8};
    vecs[5] = '{64'h102, 8'd0, 1'b0, 2, 64'h102, 64'hA2};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_last", 64'(rd_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ram_en", 64'(ram_en), 64'd0);
    check("rst_ram_wen", 64'(ram_wen), 64'd0);
    check("rst_done", 64'(done_valid), 64'd0);
    check("rst_rIdx", ram_rIdx, 64'd0);
    check("rst_wIdx", ram_wIdx, 64'd0);
    check("rst_wdata", ram_wdata, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 64'(req_ready), 64'd1);

    for (int k = 0; k < 16; k++) preload(10'(10'h100 + k), 64'hA0 + 64'(k));
    preload(10'h3FF, 64'hF0);
    preload(10'h000, 64'hF1);
    preload(10'h200, 64'hFFFF_FFFF_FFFF_FFFF);
    preload(10'h201, 64'hFFFF_FFFF_FFFF_FFFF);
    preload(10'h302, 64'h5A);

    // Table-driven read bursts.
    for (int v = 0; v < 6; v++) begin
      stall_mode = vecs[v].stall;
      i = vecs[v].idx;
      for (int k = 0; k <= int'(vecs[v].len); k++) begin
        ridx_q.push_back(i);
        rd_q.push_back('{ref_mem[i[9:0]], (k == int'(vecs[v].len))});
        i = nxt(i, vecs[v].len, vecs[v].wrap);
      end
      send_req(1'b0, vecs[v].idx, vecs[v].len, vecs[v].wrap, v == 0);
      wait_idle($sformatf("rd%0d", v));
      check($sformatf("rd%0d_last_idx", v), last_ridx, vecs[v].exp_last_idx);
      check($sformatf("rd%0d_last_data", v), last_rdata, vecs[v].exp_last_data);
    end
    stall_mode = 0;

    // Write beats offered outside a write burst are ignored.
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_data = 64'hDEAD; wr_mask = '1;
    repeat (3) begin
      @(negedge clk);
      check("idle_wr_ready", 64'(wr_ready), 64'd0);
      check("idle_ram_en", 64'(ram_en), 64'd0);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;

    // Masked write burst, back-to-back beats.
    mask = 64'hFFFF_0000_FFFF_0000;
    done_cnt = 0;
    we = '{64'h200, 64'h1111, mask, 1'b0}; wr_q.push_back(we);
    we = '{64'h201, 64'h2222, mask, 1'b1}; wr_q.push_back(we);
    send_req(1'b1, 64'h200, 8'd1, 1'b0, 1'b0);
    wr_valid = 1'b1; wr_data = 64'h1111; wr_mask = mask;
    @(negedge clk); check("wr_ready_b0", 64'(wr_ready), 64'd1);
    @(posedge clk); #1;
    wr_data = 64'h2222;
    @(negedge clk);
    check("wr_ready_b1", 64'(wr_ready), 64'd1);
    check("wr_lat_b0", 64'(ram_wen), 64'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    check("wr_lat_b1", 64'(ram_wen), 64'd1);
    check("wr_done_b1", 64'(done_valid), 64'd1);
    wait_idle("wr");
    repeat (2) @(negedge clk);
    check("wr_done_cnt", 64'(done_cnt), 64'd1);
    check("mem_200", mem[10'h200], 64'h0000_FFFF_0000_FFFF);
    check("mem_201", mem[10'h201], 64'h0000_FFFF_0000_FFFF);

    // Reset after two of eight write beats.
    done_cnt = 0;
    we = '{64'h300, 64'hC0, '1, 1'b0}; wr_q.push_back(we);
    we = '{64'h301, 64'hC1, '1, 1'b0}; wr_q.push_back(we);
    send_req(1'b1, 64'h300, 8'd7, 1'b0, 1'b0);
    wr_valid = 1'b1; wr_data = 64'hC0; wr_mask = '1;
    @(posedge clk); #1;
    wr_data = 64'hC1;
    @(posedge clk); #1;
    reset = 1'b1;
    wr_data = 64'hC2;
    @(negedge clk);
    check("rst_wr_ready_gated", 64'(wr_ready), 64'd0);
    check("rst_last_wen", 64'(ram_wen), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_ram_wen", 64'(ram_wen), 64'd0);
    check("abort_ram_en", 64'(ram_en), 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    wr_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_done_cnt", 64'(done_cnt), 64'd0);
    check("abort_wr_q", 64'(wr_q.size()), 64'd0);
    check("abort_mem_302", mem[10'h302], 64'h5A);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Burst initiator for the simulation RAM helper port (`en`/`rIdx`/`rdata`/`wIdx`/`wdata`/`wmask`/`wen`). It accepts single-command read or write bursts over valid/ready, streams write beats from a data channel and returns read beats through a 2-entry buffer. It sits between testbench traffic or DMA-style generators and the RAM helper so that either side can stall without losing beats.

## Interface
Parameters:
- `LEN_W`, 8: burst length field width; a burst is `req_len+1` beats, up to 2^LEN_W.

Ports:
- `clk` in 1: sole clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1 / `req_ready` out 1: command handshake.
- `req_write` in 1: 1 = write burst, 0 = read burst.
- `req_idx` in 64: starting 64-bit word index.
- `req_len` in LEN_W: beats minus one.
- `req_wrap` in 1: wrap-burst request (see Configuration).
- `wr_valid` in 1 / `wr_ready` out 1: write-beat handshake.
- `wr_data` in 64, `wr_mask` in 64: write beat data and bit mask.
- `rd_valid` out 1 / `rd_ready` in 1: read-beat handshake.
- `rd_data` out 64, `rd_last` out 1: read beat and last-beat flag.
- `done_valid` out 1: one-cycle pulse on write-burst completion.
- `busy` out 1: burst active or read beats in flight/buffered.
- `ram_en` out 1, `ram_rIdx` out 64, `ram_rdata` in 64, `ram_wIdx` out 64, `ram_wdata` out 64, `ram_wmask` out 64, `ram_wen` out 1: RAM helper port; `ram_rdata` is combinational from `ram_rIdx`.

## Operation
- FSM states: IDLE, READ, WRITE. Counters: `beat_idx` (64b), `beats_left` (LEN_W).
- IDLE: `req_ready`=1. On `req_valid&&req_ready` latch idx/len/wrap; go to READ or WRITE per `req_write`.
- All `ram_*` outputs are registered. `ram_en` is high only in cycles carrying a beat; otherwise `ram_en`=`ram_wen`=0, index/data hold.
- READ: issue a beat (set `ram_en`=1, `ram_rIdx`=`beat_idx` next cycle) when buffer_count + inflight − pop < 2. The in-flight beat's `ram_rdata` is pushed into the buffer at the end of its cycle, tagged `rd_last` if final. After issuing the final beat → IDLE; buffer continues to drain, and a new request may be accepted meanwhile with order preserved.
- WRITE: `wr_ready`=1. Each accepted beat drives `ram_en`=`ram_wen`=1 with `ram_wIdx`/`ram_wdata`/`ram_wmask` in the next cycle. After the final beat → IDLE, and `done_valid` pulses in the cycle `ram_wen` is high for that beat.
- Index arithmetic: `beat_idx`+1 mod 2^64 (wraps 0xFFFF_FFFF_FFFF_FFFF → 0). Wrap mode below.
- `wr_ready`=0 outside WRITE; write beats offered then are ignored.
- `busy` = state≠IDLE || inflight || buffer_count≠0.

## Timing
- Reset values: `req_ready`=0 while `reset` high, 1 in the first cycle after; `wr_ready`, `rd_valid`, `rd_last`, `done_valid`, `busy`, `ram_en`, `ram_wen` = 0; indices/data = 0. Buffer emptied, FSM → IDLE.
- Reset mid-burst aborts the burst; no further `ram_en` after the reset cycle; buffered read data discarded.
- Read latency: request accepted cycle 0, first `ram_en` cycle 2, `rd_valid` cycle 3. With `rd_ready` held 1, one beat per cycle.
- Write latency: beat accepted cycle t → `ram_wen` cycle t+1. Full throughput with `wr_valid` held 1.
- A `rd_ready` stall holds `rd_data`/`rd_last` stable; no beat is dropped or duplicated.

## Configuration
- `RAM_BURST_MASTER_WRAP_EN` defined: if `req_wrap`=1 and `req_len+1` is a power of two, index = (base & ~len) | ((beat_idx+1) & len). If `req_len+1` is not a power of two, the burst increments.
- Not defined: `req_wrap` ignored; all bursts increment.

## Test plan
- Preload words 0x100..0x103 = 0xA0..0xA3; read idx 0x100 len 3, `rd_ready`=1 → `rd_data` A0,A1,A2,A3 on consecutive cycles starting cycle 3; `rd_last` only on A3.
- Same read with `rd_ready` toggling 1010… → identical sequence, no loss; `ram_en` never issues a beat without buffer room.
- Write idx 0x200 len 1, data 0x1111/0x2222, mask 0xFFFF_0000_FFFF_0000 over preload all-ones → memory equals masked merge; `done_valid` single pulse with second `ram_wen`.
- Read idx 0xFFFF_FFFF_FFFF_FFFF len 1 → `ram_rIdx` sequence FF…FF then 0.
- WRAP_EN: read idx 0x106 len 3 wrap=1 → indices 0x106,0x107,0x104,0x105; len 2 wrap=1 → 0x106,0x107,0x108.
- Assert `reset` after 2 of 8 write beats → `ram_wen`=0 from next cycle, `req_ready`=1 after deassertion, no `done_valid`.
